// File: rtl/arbiter_pkg.sv
// Shared AER event geometry: field widths, bit offsets of the packed event word
// and a helper that splits a raw word into its named fields.
package arbiter_pkg;

  localparam int ROW_ADD = 3;
  localparam int COL_ADD = 3;
  localparam int SIZE    = 16;
  localparam int WIDTH   = SIZE + ROW_ADD + COL_ADD + 1;
  localparam int CNT_W   = 16;

  // Word layout, MSB first: {timestamp, x_add, y_add, polarity}
  localparam int POL_BIT = 0;
  localparam int Y_LSB   = POL_BIT + 1;
  localparam int Y_MSB   = Y_LSB + COL_ADD - 1;
  localparam int X_LSB   = Y_MSB + 1;
  localparam int X_MSB   = X_LSB + ROW_ADD - 1;
  localparam int TS_LSB  = X_MSB + 1;
  localparam int TS_MSB  = WIDTH - 1;

  typedef struct packed {
    logic [SIZE-1:0]    timestamp;
    logic [ROW_ADD-1:0] x_add;
    logic [COL_ADD-1:0] y_add;
    logic               polarity;
  } aer_event_t;

  function automatic aer_event_t split_event(input logic [WIDTH-1:0] w);
    aer_event_t e;
    e.timestamp = w[TS_MSB:TS_LSB];
    e.x_add     = w[X_MSB:X_LSB];
    e.y_add     = w[Y_MSB:Y_LSB];
    e.polarity  = w[POL_BIT];
    return e;
  endfunction

endpackage

// File: rtl/aer_fifo.sv
// First-word fall-through FIFO for raw event words. Storage is not reset;
// the head output reads zero whenever the FIFO is empty.
module aer_fifo #(
  parameter int WIDTH      = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign full  = (occ == OCC_W'(FIFO_DEPTH));
  assign empty = (occ == '0);
  assign dout  = empty ? '0 : mem[rptr];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PTR_W'(1);
      if (rd_ok) rptr <= rptr + PTR_W'(1);
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wptr] <= din;
  end

endmodule

// File: rtl/aer_decoder.sv
// AER event decoder: buffers packed event words, splits the head word into
// address/timestamp/polarity fields, flags timestamp regressions and counts accepts.
module aer_decoder
  import arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [WIDTH-1:0]   data_in_i,
  input  logic               valid_in_i,
  output logic               ready_in_o,
  input  logic               clear_i,
  output logic [ROW_ADD-1:0] x_add_o,
  output logic [COL_ADD-1:0] y_add_o,
  output logic [SIZE-1:0]    timestamp_o,
  output logic               polarity_o,
  output logic               valid_out_o,
  input  logic               ready_out_i,
  output logic               ts_err_o,
  output logic [CNT_W-1:0]   evt_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             full;
  logic             empty;
  logic             accept;
  logic [WIDTH-1:0] head_word;
  aer_event_t       head_evt;
  aer_event_t       in_evt;
  logic [SIZE-1:0]  last_ts;
  logic             seen;

  assign ready_in_o  = !full;
  assign valid_out_o = !empty;
  assign accept      = valid_in_i && ready_in_o;

  aer_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (valid_in_i),
    .din     (data_in_i),
    .pop     (ready_out_i),
    .dout    (head_word),
    .full    (full),
    .empty   (empty)
  );

  assign head_evt    = split_event(head_word);
  assign in_evt      = split_event(data_in_i);
  assign x_add_o     = head_evt.x_add;
  assign y_add_o     = head_evt.y_add;
  assign timestamp_o = head_evt.timestamp;
  assign polarity_o  = head_evt.polarity;

  // Clear wins over a coincident accept for the flag and counter, but the
  // order tracker still records the accepted timestamp.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_ts   <= '0;
      seen      <= 1'b0;
      ts_err_o  <= 1'b0;
      evt_cnt_o <= '0;
    end else begin
      if (accept) begin
        last_ts <= in_evt.timestamp;
        seen    <= 1'b1;
      end
      if (clear_i) begin
        ts_err_o  <= 1'b0;
        evt_cnt_o <= '0;
      end else if (accept) begin
        evt_cnt_o <= sat_inc(evt_cnt_o);
        if (seen && (in_evt.timestamp < last_ts)) ts_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aer_decoder.sv
// Randomized and directed bench for aer_decoder against a queue-based event model.
module tb_aer_decoder;
  import arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic               clk_i;
  logic               reset_i;
  logic [WIDTH-1:0]   data_in_i;
  logic               valid_in_i;
  logic               ready_in_o;
  logic               clear_i;
  logic [ROW_ADD-1:0] x_add_o;
  logic [COL_ADD-1:0] y_add_o;
  logic [SIZE-1:0]    timestamp_o;
  logic               polarity_o;
  logic               valid_out_o;
  logic               ready_out_i;
  logic               ts_err_o;
  logic [15:0]        evt_cnt_o;

  aer_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .data_in_i   (data_in_i),
    .valid_in_i  (valid_in_i),
    .ready_in_o  (ready_in_o),
    .clear_i     (clear_i),
    .x_add_o     (x_add_o),
    .y_add_o     (y_add_o),
    .timestamp_o (timestamp_o),
    .polarity_o  (polarity_o),
    .valid_out_o (valid_out_o),
    .ready_out_i (ready_out_i),
    .ts_err_o    (ts_err_o),
    .evt_cnt_o   (evt_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: queue of buffered words plus scalar status
  logic [WIDTH-1:0] mq[$];
  bit               m_err;
  int               m_cnt;
  int               m_last;
  bit               m_seen;
  bit               chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int ts, input int x, input int y, input int p);
    logic [SIZE-1:0]    t;
    logic [ROW_ADD-1:0] xa;
    logic [COL_ADD-1:0] ya;
    logic               pa;
    t = SIZE'(ts); xa = ROW_ADD'(x); ya = COL_ADD'(y); pa = p[0];
    return {t, xa, ya, pa};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_err = 0; m_cnt = 0; m_last = 0; m_seen = 0;
  endtask

  // Applies the spec rules for one rising edge using the inputs held across it
  task automatic model_edge();
    bit acc, emit;
    int ts;
    acc  = valid_in_i && (mq.size() < DEPTH);
    emit = ready_out_i && (mq.size() > 0);
    ts   = int'(data_in_i) / (1 << (WIDTH - SIZE));
    if (emit) void'(mq.pop_front());
    if (acc) mq.push_back(data_in_i);
    if (clear_i) begin
      m_cnt = 0;
      m_err = 0;
    end else if (acc) begin
      if (m_seen && ts < m_last) m_err = 1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (acc) begin
      m_last = ts;
      m_seen = 1;
    end
  endtask

  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic c);
    valid_in_i  = v;
    data_in_i   = d;
    ready_out_i = r;
    clear_i     = c;
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    model_reset();
    #3;
    reset_i = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (chk_on) begin
        logic [WIDTH-1:0] h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("valid_out", 32'(valid_out_o), 32'(mq.size() > 0));
        chk("ready_in", 32'(ready_in_o), 32'(mq.size() < DEPTH));
        chk("timestamp", 32'(timestamp_o), 32'(int'(h) / (1 << (WIDTH - SIZE))));
        chk("x_add", 32'(x_add_o), 32'((int'(h) / (1 << (COL_ADD + 1))) % (1 << ROW_ADD)));
        chk("y_add", 32'(y_add_o), 32'((int'(h) / 2) % (1 << COL_ADD)));
        chk("polarity", 32'(polarity_o), 32'(int'(h) % 2));
        chk("ts_err", 32'(ts_err_o), 32'(m_err));
        chk("evt_cnt", 32'(evt_cnt_o), 32'(m_cnt));
      end
    end
  end

  initial begin
    reset_i = 1'b1; valid_in_i = 1'b0; data_in_i = '0;
    ready_out_i = 1'b0; clear_i = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", 32'(valid_out_o), 32'd0);
    chk("rst_ready", 32'(ready_in_o), 32'd1);
    chk("rst_cnt", 32'(evt_cnt_o), 32'd0);
    chk("rst_err", 32'(ts_err_o), 32'd0);
    #4;
    reset_i = 1'b0;
    chk_on = 1'b1;

    // Single-event decode
    step(1'b1, mk(16'h0100, 5, 2, 1), 1'b1, 1'b0);
    chk("dec_x", 32'(x_add_o), 32'd5);
    chk("dec_y", 32'(y_add_o), 32'd2);
    chk("dec_ts", 32'(timestamp_o), 32'h0100);
    chk("dec_pol", 32'(polarity_o), 32'd1);
    chk("dec_valid", 32'(valid_out_o), 32'd1);
    chk("dec_cnt", 32'(evt_cnt_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("dec_drained", 32'(valid_out_o), 32'd0);

    // Fill and backpressure
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(ready_in_o), 32'd1);
      step(1'b1, mk(16'h1000 + i, i, 7 - i, i % 2), 1'b0, 1'b0);
    end
    chk("full_ready", 32'(ready_in_o), 32'd0);
    step(1'b1, mk(16'h2000, 1, 1, 1), 1'b0, 1'b0);
    chk("held_cnt", 32'(evt_cnt_o), 32'd4);
    chk("held_head", 32'(timestamp_o), 32'h1000);
    for (int i = 0; i < 4; i++) begin
      chk("drain_ts", 32'(timestamp_o), 32'(16'h1000 + i));
      chk("drain_x", 32'(x_add_o), 32'(i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(valid_out_o), 32'd0);

    // Timestamp order
    do_reset();
    step(1'b1, mk(16'h0200, 1, 1, 0), 1'b1, 1'b0);
    step(1'b1, mk(16'h0200, 2, 2, 1), 1'b1, 1'b0);
    chk("ord_equal", 32'(ts_err_o), 32'd0);
    step(1'b1, mk(16'h01FF, 3, 3, 0), 1'b1, 1'b0);
    chk("ord_viol", 32'(ts_err_o), 32'd1);
    step(1'b1, mk(16'h0300, 3, 3, 0), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("ord_sticky", 32'(ts_err_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("ord_clear", 32'(ts_err_o), 32'd0);

    // Clear with simultaneous accept
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, mk((i == 3) ? 0 : 16'h0400 + i, i, i, 1), 1'b1, 1'b0);
    chk("clr_pre_cnt", 32'(evt_cnt_o), 32'd7);
    chk("clr_pre_err", 32'(ts_err_o), 32'd1);
    step(1'b1, mk(16'h0500, 1, 2, 0), 1'b1, 1'b1);
    chk("clr_cnt", 32'(evt_cnt_o), 32'd0);
    chk("clr_err", 32'(ts_err_o), 32'd0);
    chk("clr_buffered", 32'(timestamp_o), 32'h0500);
    step(1'b1, mk(16'h04FF, 1, 2, 0), 1'b1, 1'b0);
    chk("clr_last_kept", 32'(ts_err_o), 32'd1);

    // Reset mid-operation, checked without a clock edge
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, mk(16'h0600 + i, 6, 6, 1), 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(valid_out_o), 32'd1);
    reset_i = 1'b1;
    model_reset();
    #1;
    chk("mid_valid", 32'(valid_out_o), 32'd0);
    chk("mid_cnt", 32'(evt_cnt_o), 32'd0);
    chk("mid_ready", 32'(ready_in_o), 32'd1);
    chk("mid_ts", 32'(timestamp_o), 32'd0);
    #1;
    reset_i = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("mid_no_emit", 32'(valid_out_o), 32'd0);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [WIDTH-1:0] d;
      int ts;
      ts = (i * 8 + int'($urandom_range(0, 15)) - 4) & 16'hFFFF;
      if ($urandom_range(0, 9) == 0) ts = int'($urandom_range(0, 65535));
      d = mk(ts, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)));
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
    end

    // Counter saturation
    step(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 65540; i++) step(1'b1, mk(16'h0700, 0, 0, 0), 1'b1, 1'b0);
    chk("sat_cnt", 32'(evt_cnt_o), 32'hFFFF);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
